// File: rtl/digit_renderer_if.sv
// Height-value handshake between a producer and the digit renderer's BCD converter.
interface digit_renderer_if;
  logic [9:0] value;
  logic       value_valid;
  logic       in_ready;

  modport master (output value, output value_valid, input in_ready);
  modport slave  (input value, input value_valid, output in_ready);
endinterface

// File: rtl/digit_renderer.sv
// Three-digit decimal readout overlay: sequential binary-to-BCD converter plus a
// two-stage render pipeline that addresses the glyph ROM and muxes its pixel.
module digit_renderer #(
  parameter int         X0       = 288,
  parameter int         Y0       = 224,
  parameter int         SCALE    = 1,
  parameter logic [5:0] BG_COLOR = 6'b000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  digit_renderer_if.slave   vin,
  output logic [3:0]        rom_sel,
  output logic [4:0]        rom_col,
  output logic [4:0]        rom_row,
  input  logic [5:0]        rom_data,
  output logic [5:0]        pixel_out,
  output logic [11:0]       bcd_shown
);

  localparam logic [10:0] XL = 11'(X0);
  localparam logic [10:0] XH = 11'(X0 + (24 << SCALE));
  localparam logic [10:0] YL = 11'(Y0);
  localparam logic [10:0] YH = 11'(Y0 + (16 << SCALE));
  localparam logic [5:0]  BLANK_COLOR = 6'b111111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  function automatic logic [9:0] sat999(input logic [9:0] v);
    return (v > 10'd999) ? 10'd999 : v;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  bin_q, bin_d;
  logic [11:0] acc_q, acc_d, acc_adj;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] pend_q, pend_d;
  logic [11:0] shown_q, shown_d;
  logic        frame_start;

  always_comb begin
    state_d       = state_q;
    bin_d         = bin_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    shown_d       = shown_q;
    vin.in_ready  = (state_q == S_IDLE);
    acc_adj       = {add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};
    frame_start   = (hcount == 10'd0) && (vcount == 10'd0);
    case (state_q)
      S_IDLE: begin
        if (vin.value_valid) begin
          bin_d   = sat999(vin.value);
          acc_d   = 12'h000;
          cnt_d   = 4'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = {acc_adj[10:0], bin_q[9]};
        bin_d = {bin_q[8:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) state_d = S_DONE;
      end
      S_DONE: begin
        pend_d  = acc_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A conversion finishing exactly on frame start bypasses pending so it shows this frame.
    if (frame_start) shown_d = (state_q == S_DONE) ? acc_q : pend_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      shown_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      shown_q <= shown_d;
    end
  end

  logic [10:0] h11, v11, dx, dy;
  logic [1:0]  idx;
  logic [3:0]  sel_p1_d, sel_p1_q;
  logic [2:0]  col_p1_d, col_p1_q;
  logic [3:0]  row_p1_d, row_p1_q;
  logic        box_p1_d, box_p1_q, blank_p1_d, blank_p1_q;
  logic [5:0]  pix_p2_d, pix_p2_q;

  // Stage 1: scan coordinate -> glyph address and cell flags
  always_comb begin
    h11      = {1'b0, hcount};
    v11      = {1'b0, vcount};
    dx       = h11 - XL;
    dy       = v11 - YL;
    box_p1_d = (h11 >= XL) && (h11 < XH) && (v11 >= YL) && (v11 < YH);
    idx      = 2'(dx >> (3 + SCALE));
    col_p1_d = 3'(dx >> SCALE);
    row_p1_d = 4'(dy >> SCALE);
    case (idx)
      2'd0: begin
        sel_p1_d   = shown_q[11:8];
        blank_p1_d = (shown_q[11:8] == 4'd0);
      end
      2'd1: begin
        sel_p1_d   = shown_q[7:4];
        blank_p1_d = (shown_q[11:4] == 8'd0);
      end
      default: begin
        sel_p1_d   = shown_q[3:0];
        blank_p1_d = 1'b0;
      end
    endcase
  end

  // Stage 2: select glyph pixel, blank colour or background
  always_comb begin
    pix_p2_d = BG_COLOR;
    if (box_p1_q) pix_p2_d = blank_p1_q ? BLANK_COLOR : rom_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_p1_q   <= '0;
      col_p1_q   <= '0;
      row_p1_q   <= '0;
      box_p1_q   <= 1'b0;
      blank_p1_q <= 1'b0;
      pix_p2_q   <= BG_COLOR;
    end else begin
      sel_p1_q   <= sel_p1_d;
      col_p1_q   <= col_p1_d;
      row_p1_q   <= row_p1_d;
      box_p1_q   <= box_p1_d;
      blank_p1_q <= blank_p1_d;
      pix_p2_q   <= pix_p2_d;
    end
  end

  assign rom_sel   = sel_p1_q;
  assign rom_col   = {2'b00, col_p1_q};
  assign rom_row   = {1'b0, row_p1_q};
  assign pixel_out = pix_p2_q;
  assign bcd_shown = shown_q;

endmodule

// File: tb/tb_digit_renderer.sv
// Randomized self-checking bench for digit_renderer against an arithmetic reference model.
module tb_digit_renderer;
  localparam int         X0    = 288;
  localparam int         Y0    = 224;
  localparam int         SCALE = 1;
  localparam logic [5:0] BG    = 6'b000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount, vcount;
  logic [3:0]  rom_sel;
  logic [4:0]  rom_col, rom_row;
  logic [5:0]  rom_data, pixel_out;
  logic [11:0] bcd_shown;
  int          n_cmp = 0;
  int          n_bad = 0;

  digit_renderer_if dif ();

  digit_renderer #(.X0(X0), .Y0(Y0), .SCALE(SCALE), .BG_COLOR(BG)) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .vin(dif),
    .rom_sel(rom_sel), .rom_col(rom_col), .rom_row(rom_row), .rom_data(rom_data),
    .pixel_out(pixel_out), .bcd_shown(bcd_shown)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] rom_fn(input logic [3:0] s, input logic [4:0] c, input logic [4:0] r);
    int t;
    t = int'(s) * 11 + int'(c) * 5 + int'(r) * 3 + 1;
    return 6'(t % 64);
  endfunction

  assign rom_data = rom_fn(rom_sel, rom_col, rom_row);

  function automatic logic [11:0] exp_bcd(input int v);
    int s;
    s = (v > 999) ? 999 : v;
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // Reference: what the screen should show at (h,v) for displayed digits d.
  task automatic ref_model(input int h, input int v, input logic [11:0] d,
                           output bit inb, output int sel, output int col,
                           output int row, output logic [5:0] pix);
    int w, u, k, val;
    bit blank;
    w   = 8 << SCALE;
    u   = 1 << SCALE;
    val = int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
    inb = (h >= X0) && (h < X0 + 3 * w) && (v >= Y0) && (v < Y0 + 2 * w);
    sel = 0; col = 0; row = 0; pix = BG;
    if (inb) begin
      k     = (h - X0) / w;
      col   = ((h - X0) / u) % 8;
      row   = ((v - Y0) / u) % 16;
      sel   = (k == 0) ? val / 100 : (k == 1) ? (val / 10) % 10 : val % 10;
      blank = (k == 0 && val < 100) || (k == 1 && val < 10);
      pix   = blank ? 6'h3F : rom_fn(4'(sel), 5'(col), 5'(row));
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    hcount = 10'd1;
    vcount = 10'd1;
  endtask

  task automatic frame();
    hcount = 10'd0;
    vcount = 10'd0;
    step();
    park();
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!dif.in_ready && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic accept(input int v);
    wait_ready();
    dif.value       = 10'(v);
    dif.value_valid = 1'b1;
    step();
    dif.value_valid = 1'b0;
  endtask

  task automatic drive_pt(input int h, input int v);
    hcount = 10'(h);
    vcount = 10'(v);
    step();
    step();
  endtask

  // Stream random coordinates; rom_* lag one cycle, pixel_out lags two.
  task automatic scan(input int n, input logic [11:0] d);
    int hs[64], vs[64];
    bit inb;
    int es, ec, er;
    logic [5:0] ep;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        hs[i]  = X0 - 3 + int'($urandom_range(0, 54));
        vs[i]  = Y0 - 3 + int'($urandom_range(0, 38));
        hcount = 10'(hs[i]);
        vcount = 10'(vs[i]);
      end
      step();
      if (i < n) begin
        ref_model(hs[i], vs[i], d, inb, es, ec, er, ep);
        if (inb) begin
          check("scan_sel", 32'(rom_sel), 32'(es));
          check("scan_col", 32'(rom_col), 32'(ec));
          check("scan_row", 32'(rom_row), 32'(er));
        end
      end
      if (i >= 1) begin
        ref_model(hs[i-1], vs[i-1], d, inb, es, ec, er, ep);
        check("scan_pix", 32'(pixel_out), 32'(ep));
      end
    end
    park();
  endtask

  initial begin
    int lows, v;
    reset           = 1'b1;
    hcount          = 10'd0;
    vcount          = 10'd0;
    dif.value       = 10'd0;
    dif.value_valid = 1'b0;
    step();
    step();
    check("rst_sel", 32'(rom_sel), 32'd0);
    check("rst_col", 32'(rom_col), 32'd0);
    check("rst_row", 32'(rom_row), 32'd0);
    reset = 1'b0;
    step();
    check("rst_ready", 32'(dif.in_ready), 32'd1);
    check("rst_bcd", 32'(bcd_shown), 32'h000);
    check("rst_pix", 32'(pixel_out), 32'(BG));
    park();

    accept(123);
    lows = 0;
    while (!dif.in_ready && lows < 50) begin
      lows++;
      step();
    end
    check("busy_cycles", 32'(lows), 32'd11);
    step();
    check("no_tear", 32'(bcd_shown), 32'h000);
    frame();
    check("frame_123", 32'(bcd_shown), 32'h123);

    accept(1000);
    dif.value       = 10'd5;
    dif.value_valid = 1'b1;
    repeat (4) step();
    dif.value_valid = 1'b0;
    wait_ready();
    repeat (3) step();
    frame();
    check("sat_999", 32'(bcd_shown), 32'h999);
    repeat (20) step();
    frame();
    check("drop_busy", 32'(bcd_shown), 32'h999);

    accept(7);
    wait_ready();
    frame();
    check("bcd_7", 32'(bcd_shown), 32'h007);
    drive_pt(X0 + 3, Y0 + 3);
    check("blank_hund", 32'(pixel_out), 32'h3F);
    drive_pt(X0 + 20, Y0 + 10);
    check("blank_tens", 32'(pixel_out), 32'h3F);
    drive_pt(X0 + 35, Y0 + 7);
    check("units_7", 32'(rom_sel), 32'd7);
    scan(20, 12'h007);

    accept(40);
    wait_ready();
    frame();
    drive_pt(X0 + 5, Y0 + 20);
    check("blank40_h", 32'(pixel_out), 32'h3F);
    drive_pt(X0 + 25, Y0 + 20);
    check("tens_4", 32'(rom_sel), 32'd4);
    drive_pt(X0 + 40, Y0 + 20);
    check("units_0", 32'(rom_sel), 32'd0);

    hcount = 10'(X0 + 17);
    vcount = 10'(Y0 + 5);
    step();
    check("geo_sel", 32'(rom_sel), 32'd4);
    check("geo_col", 32'(rom_col), 32'd0);
    check("geo_row", 32'(rom_row), 32'd2);
    step();
    check("geo_pix", 32'(pixel_out), 32'(rom_fn(4'd4, 5'd0, 5'd2)));
    drive_pt(X0 - 1, Y0 + 5);
    check("left_bg", 32'(pixel_out), 32'(BG));
    drive_pt(X0 + 48, Y0 + 5);
    check("right_bg", 32'(pixel_out), 32'(BG));
    park();

    accept(456);
    repeat (10) step();
    check("done_busy", 32'(dif.in_ready), 32'd0);
    frame();
    check("coincide", 32'(bcd_shown), 32'h456);

    accept(888);
    repeat (4) step();
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(dif.in_ready), 32'd1);
    check("mid_rst_bcd", 32'(bcd_shown), 32'h000);
    #2;
    reset = 1'b0;
    repeat (15) step();
    frame();
    check("abort_bcd", 32'(bcd_shown), 32'h000);

    for (int r = 0; r < 6; r++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 1023));
      accept(v);
      wait_ready();
      frame();
      check("rand_bcd", 32'(bcd_shown), 32'(exp_bcd(v)));
      scan(30, exp_bcd(v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
